// File: rtl/layer_sequencer.sv
// layer_sequencer: launches each LeNet layer engine in turn and waits for
// its finish, with a settle gap, watchdog and stray-finish flag.
module layer_sequencer #(
    parameter int NUM_LAYERS     = 5,
    parameter int IDX_W          = 3,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_finish,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  stray
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t                state;
    state_t                nxt;
    logic [IDX_W-1:0]      nxt_cur;
    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      gap_cnt;
    logic [CNT_W-1:0]      nxt_wait;
    logic [CNT_W-1:0]      nxt_gap;
    logic [NUM_LAYERS-1:0] cur_mask;
    logic [NUM_LAYERS-1:0] launch_mask;
    logic                  fin_cur;
    logic                  fin_other;
    logic                  fin_any;
    logic                  busy_st;
    logic                  stray_hit;
    logic                  accept;

    assign cur_mask    = NUM_LAYERS'(1) << cur_layer;
    assign launch_mask = NUM_LAYERS'(1) << nxt_cur;
    assign fin_cur     = |(layer_finish & cur_mask);
    assign fin_other   = |(layer_finish & ~cur_mask);
    assign fin_any     = |layer_finish;

    assign busy_st = (state == S_LAUNCH) ||
                     (state == S_WAIT) ||
                     (state == S_GAP);

    // In a pass only the awaited layer may finish; otherwise none may.
    assign stray_hit = busy_st ? fin_other : fin_any;
    assign accept    = (state == S_IDLE) && start && !abort;

    always_comb begin
        nxt      = state;
        nxt_cur  = cur_layer;
        nxt_wait = wait_cnt;
        nxt_gap  = gap_cnt;
        if (abort) begin
            nxt      = S_IDLE;
            nxt_wait = '0;
            nxt_gap  = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        nxt     = S_LAUNCH;
                        nxt_cur = '0;
                    end
                end
                S_LAUNCH: begin
                    nxt      = S_WAIT;
                    nxt_wait = '0;
                end
                S_WAIT: begin
                    if (fin_cur) begin
                        if (cur_layer == LAST_IDX) begin
                            nxt = S_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            nxt     = S_LAUNCH;
                            nxt_cur = cur_layer + IDX_ONE;
                        end else begin
                            nxt     = S_GAP;
                            nxt_gap = '0;
                        end
                    end else if (TIMEOUT_CYCLES != 0 &&
                                 wait_cnt == TO_LAST) begin
                        nxt = S_ERR;
                    end else if (wait_cnt != CNT_MAX) begin
                        nxt_wait = wait_cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        nxt     = S_LAUNCH;
                        nxt_cur = cur_layer + IDX_ONE;
                    end else begin
                        nxt_gap = gap_cnt + CNT_ONE;
                    end
                end
                S_DONE: nxt = S_IDLE;
                S_ERR:  nxt = S_ERR;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_layer   <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            layer_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            stray       <= 1'b0;
        end else begin
            state       <= nxt;
            cur_layer   <= nxt_cur;
            wait_cnt    <= nxt_wait;
            gap_cnt     <= nxt_gap;
            layer_start <= (nxt == S_LAUNCH) ? launch_mask : '0;
            busy        <= (nxt == S_LAUNCH) ||
                           (nxt == S_WAIT) ||
                           (nxt == S_GAP);
            done        <= (nxt == S_DONE);
            timeout     <= (nxt == S_ERR);
            stray       <= (accept ? 1'b0 : stray) | stray_hit;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed and random checks of layer_sequencer
// against a cycle-timing model, on a gapped/watchdog and a gapless instance.
module tb_layer_sequencer;

    localparam int NL = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] fin = '0;

    logic [NL-1:0] u0_ls, u1_ls;
    logic [2:0]    u0_cur, u1_cur;
    logic          u0_busy, u0_done, u0_to, u0_stray;
    logic          u1_busy, u1_done, u1_to, u1_stray;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_LAYERS(NL), .IDX_W(3), .GAP_CYCLES(1),
        .TIMEOUT_CYCLES(16), .CNT_W(16)
    ) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_finish(fin), .layer_start(u0_ls), .cur_layer(u0_cur),
        .busy(u0_busy), .done(u0_done), .timeout(u0_to), .stray(u0_stray)
    );

    layer_sequencer #(
        .NUM_LAYERS(NL), .IDX_W(3), .GAP_CYCLES(0),
        .TIMEOUT_CYCLES(0), .CNT_W(16)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_finish(fin), .layer_start(u1_ls), .cur_layer(u1_cur),
        .busy(u1_busy), .done(u1_done), .timeout(u1_to), .stray(u1_stray)
    );

    // Model: a pass is described by the cycle of its next launch pulse
    // and the cycle of its done pulse, rather than by a state machine.
    typedef struct packed {
        bit running;
        bit hung;
        bit stray;
        int target;
        int cur;
        int next_launch;
        int done_at;
    } mdl_t;

    typedef struct packed {
        logic [NL-1:0] ls;
        logic [2:0]    cur;
        logic          busy;
        logic          done;
        logic          to;
        logic          stray;
    } obs_t;

    function automatic mdl_t mstep(mdl_t m, int n, int gap, int to,
                                   logic r, logic s, logic a,
                                   logic [NL-1:0] f);
        mdl_t q;
        logic [NL-1:0] mine;
        bit hit, ns;
        q = m;
        if (r) begin
            q.running = 0; q.hung = 0; q.stray = 0;
            q.target = 0; q.cur = 0;
            q.next_launch = -1; q.done_at = -1;
            return q;
        end
        mine = NL'(1) << q.cur;
        hit = q.running ? (|(f & ~mine)) : (|f);
        ns = q.stray;
        if (a) begin
            q.running = 0;
            q.hung = 0;
        end else if (!q.running && !q.hung && n != q.done_at) begin
            if (s) begin
                q.running = 1;
                q.target = 0;
                q.next_launch = n + 1;
                ns = 0;
            end
        end else if (q.running && n > q.next_launch) begin
            if (f[q.target]) begin
                if (q.target == NL - 1) begin
                    q.running = 0;
                    q.done_at = n + 1;
                end else begin
                    q.target = q.target + 1;
                    q.next_launch = n + 1 + gap;
                end
            end else if (to != 0 && n - q.next_launch == to) begin
                q.running = 0;
                q.hung = 1;
            end
        end
        if (q.running && q.next_launch == n + 1) q.cur = q.target;
        q.stray = ns | hit;
        return q;
    endfunction

    function automatic obs_t mexp(mdl_t m, int n);
        obs_t o;
        o.ls    = (m.running && n == m.next_launch) ?
                  (NL'(1) << m.target) : '0;
        o.cur   = 3'(m.cur);
        o.busy  = m.running;
        o.done  = (n == m.done_at);
        o.to    = m.hung;
        o.stray = m.stray;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("ls=%b cur=%0d busy=%b done=%b to=%b stray=%b",
                         o.ls, o.cur, o.busy, o.done, o.to, o.stray);
    endfunction

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0 = 0;
    bit   armed = 0;
    bit   log_en = 0;
    mdl_t m0, m1;
    obs_t e0, e1, a0, a1;

    int            ls0_t[$], ls1_t[$];
    logic [NL-1:0] ls0_v[$], ls1_v[$];
    int            done0_t, done1_t, busy0_n, busy1_n;

    always @(posedge clk) begin
        m0 <= mstep(m0, cyc, 1, 16, rst, start, abort, fin);
        m1 <= mstep(m1, cyc, 0, 0, rst, start, abort, fin);
        if (rst) armed <= 1'b1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            e0 = mexp(m0, cyc);
            e1 = mexp(m1, cyc);
            a0 = {u0_ls, u0_cur, u0_busy, u0_done, u0_to, u0_stray};
            a1 = {u1_ls, u1_cur, u1_busy, u1_done, u1_to, u1_stray};
            checks = checks + 2;
            if (a0 !== e0) begin
                errors++;
                $display("FAIL u0_cycle %0d: got %s want %s",
                         cyc, fmt(a0), fmt(e0));
            end
            if (a1 !== e1) begin
                errors++;
                $display("FAIL u1_cycle %0d: got %s want %s",
                         cyc, fmt(a1), fmt(e1));
            end
        end
        if (log_en) begin
            if (u0_ls != '0) begin
                ls0_t.push_back(cyc - t0);
                ls0_v.push_back(u0_ls);
            end
            if (u1_ls != '0) begin
                ls1_t.push_back(cyc - t0);
                ls1_v.push_back(u1_ls);
            end
            if (u0_done && done0_t < 0) done0_t = cyc - t0;
            if (u1_done && done1_t < 0) done1_t = cyc - t0;
            if (u0_busy) busy0_n++;
            if (u1_busy) busy1_n++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic go_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; fin = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic begin_pass();
        ls0_t.delete(); ls0_v.delete();
        ls1_t.delete(); ls1_v.delete();
        done0_t = -1; done1_t = -1;
        busy0_n = 0; busy1_n = 0;
        t0 = cyc;
        log_en = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_fin(input int layer, input int at);
        go_until(t0 + at);
        fin = NL'(1) << layer;
        tick(1);
        fin = '0;
    endtask

    initial begin
        int lit_g1[5];
        int lit_g0[5];
        lit_g1 = '{1, 13, 25, 37, 49};
        lit_g0 = '{1, 3, 5, 7, 9};

        do_reset();
        chk("rst_ls", int'(u0_ls), 0);
        chk("rst_cur", int'(u0_cur), 0);
        chk("rst_busy", int'(u0_busy), 0);
        chk("rst_done", int'(u0_done), 0);
        chk("rst_timeout", int'(u0_to), 0);
        chk("rst_stray", int'(u0_stray), 0);

        // full pass, gap 1, each layer finishes 10 cycles after launch
        begin_pass();
        for (int i = 0; i < NL; i++) pulse_fin(i, 11 + 12 * i);
        go_until(t0 + 64);
        log_en = 1'b0;
        chk("gap1_nlaunch", ls0_t.size(), 5);
        for (int i = 0; i < NL; i++) begin
            if (i < ls0_t.size()) begin
                chk("gap1_launch_cyc", ls0_t[i], lit_g1[i]);
                chk("gap1_launch_val", int'(ls0_v[i]), 1 << i);
            end
        end
        chk("gap1_done_cyc", done0_t, 60);
        chk("gap1_busy_cycles", busy0_n, 59);
        chk("gap1_stray", int'(u0_stray), 0);

        // gapless pass, finish in the first wait cycle
        do_reset();
        begin_pass();
        for (int i = 0; i < NL; i++) pulse_fin(i, 2 + 2 * i);
        go_until(t0 + 14);
        log_en = 1'b0;
        chk("gap0_nlaunch", ls1_t.size(), 5);
        for (int i = 0; i < NL; i++) begin
            if (i < ls1_t.size()) begin
                chk("gap0_launch_cyc", ls1_t[i], lit_g0[i]);
                chk("gap0_launch_val", int'(ls1_v[i]), 1 << i);
            end
        end
        chk("gap0_done_cyc", done1_t, 11);
        chk("gap0_busy_cycles", busy1_n, 10);
        chk("gap0_stray", int'(u1_stray), 0);

        // watchdog: layer 2 hangs
        do_reset();
        begin_pass();
        pulse_fin(0, 11);
        pulse_fin(1, 23);
        go_until(t0 + 41);
        chk("wd_pre_timeout", int'(u0_to), 0);
        chk("wd_pre_busy", int'(u0_busy), 1);
        tick(1);
        chk("wd_timeout", int'(u0_to), 1);
        chk("wd_cur", int'(u0_cur), 2);
        chk("wd_busy", int'(u0_busy), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("wd_start_ignored_ls", int'(u0_ls), 0);
        tick(2);
        chk("wd_still_timeout", int'(u0_to), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("wd_abort_timeout", int'(u0_to), 0);
        chk("wd_abort_busy", int'(u0_busy), 0);
        log_en = 1'b0;

        // finish on the last allowed wait cycle beats the watchdog
        do_reset();
        begin_pass();
        pulse_fin(0, 17);
        go_until(t0 + 18);
        chk("wd_edge_timeout", int'(u0_to), 0);
        chk("wd_edge_gap_busy", int'(u0_busy), 1);
        tick(1);
        chk("wd_edge_launch1", int'(u0_ls), 2);
        chk("wd_edge_cur", int'(u0_cur), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        log_en = 1'b0;

        // stray finish of layer 3 while awaiting layer 1
        do_reset();
        begin_pass();
        pulse_fin(0, 11);
        go_until(t0 + 15);
        chk("stray_before", int'(u0_stray), 0);
        pulse_fin(3, 15);
        chk("stray_set", int'(u0_stray), 1);
        pulse_fin(1, 23);
        go_until(t0 + 25);
        chk("stray_launch2", int'(u0_ls), 4);
        chk("stray_sticky", int'(u0_stray), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        begin_pass();
        chk("stray_cleared", int'(u0_stray), 0);
        chk("stray_new_launch", int'(u0_ls), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        log_en = 1'b0;

        // reset in the gap after layer 2, then a clean pass
        do_reset();
        begin_pass();
        pulse_fin(0, 11);
        pulse_fin(1, 23);
        pulse_fin(2, 35);
        go_until(t0 + 36);
        chk("mid_gap_busy", int'(u0_busy), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_ls", int'(u0_ls), 0);
        chk("mid_rst_busy", int'(u0_busy), 0);
        chk("mid_rst_cur", int'(u0_cur), 0);
        chk("mid_rst_done", int'(u0_done), 0);
        begin_pass();
        chk("post_rst_launch", int'(u0_ls), 1);
        tick(1);
        chk("post_rst_wait_ls", int'(u0_ls), 0);
        chk("post_rst_wait_busy", int'(u0_busy), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_ls", int'(u0_ls), 0);
        chk("abort_start_busy", int'(u0_busy), 0);
        tick(1);
        chk("abort_start_ls2", int'(u0_ls), 0);
        log_en = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < NL; b++)
                fin[b] = ($urandom_range(0, 6) == 0);
            tick(1);
        end
        rst = 1'b0; abort = 1'b0; start = 1'b0; fin = '0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
